// File: rtl/arq_pkg.sv
// Shared constants and types for the eight-entry register bank and its scan sequencer.
package arq_pkg;

  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;
  localparam int WORD_W   = 16;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/reg_bank_scan_8x16_scan_seq.sv
// Scan sequencer: walks sel through every bank entry after a start pulse,
// then emits a one-cycle done. All outputs come straight from flops.
module reg_bank_scan_8x16_scan_seq
  import arq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  output logic             scan_vld,
  output logic             busy,
  output logic             done
);

  scan_state_t      state_q, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic             vld_q, busy_q, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      vld_q   <= (state_nxt == SCAN);
      busy_q  <= (state_nxt == SCAN);
      done_q  <= (state_nxt == DONE);
    end
  end

  // start is only honoured in IDLE; it never restarts or stretches a scan
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    case (state_q)
      IDLE: begin
        sel_nxt = '0;
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        if (sel_q == LAST_SEL) begin
          state_nxt = DONE;
          sel_nxt   = '0;
        end else begin
          sel_nxt = sel_q + SEL_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  assign sel      = sel_q;
  assign scan_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/reg_bank_scan_8x16.sv
// Eight-entry register bank feeding an 8:1 selector, with a built-in scan sequencer.
// Build option REG_BANK_ZERO_R0_EN hardwires entry 0 to zero and drops writes to it.
module reg_bank_scan_8x16
  import arq_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             start,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [2:0]       sel,
  output logic             scan_vld,
  output logic             busy,
  output logic             done
);

`ifdef REG_BANK_ZERO_R0_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Writes land in every sequencer state; a write to the entry being scanned
  // shows up only from the following cycle.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [WIDTH-1:0] r_q;
    if (R0_ZERO && (i == 0)) begin : g_zero
      assign r_q = '0;
    end else begin : g_live
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= RESET_VAL;
        end else if (we && (waddr == SEL_W'(i))) begin
          r_q <= wdata;
        end
      end
    end
  end

  assign q0 = g_reg[0].r_q;
  assign q1 = g_reg[1].r_q;
  assign q2 = g_reg[2].r_q;
  assign q3 = g_reg[3].r_q;
  assign q4 = g_reg[4].r_q;
  assign q5 = g_reg[5].r_q;
  assign q6 = g_reg[6].r_q;
  assign q7 = g_reg[7].r_q;

  reg_bank_scan_8x16_scan_seq u_scan_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sel      (sel),
    .scan_vld (scan_vld),
    .busy     (busy),
    .done     (done)
  );

endmodule
